// File: rtl/huffman_merge_engine.sv
// Huffman tree merge engine: loads NSYM leaf counts, then repeatedly merges the two
// smallest active nodes and streams one record per merge. Optional macro: HME_ZERO_SKIP_EN.
module huffman_merge_engine #(
  parameter int NSYM = 6,
  parameter int CW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [CW-1:0]     load_data,
  output logic              load_ready,
  output logic              merge_valid,
  input  logic              merge_ready,
  output logic [CW+3:0]     merge_sum,
  output logic [NSYM-1:0]   merge_mask_a,
  output logic [NSYM-1:0]   merge_mask_b,
  output logic              busy,
  output logic              done
);

  localparam int NW = CW + 4;
  localparam int IW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int KW = NW + NSYM;
  localparam logic [IW-1:0] LAST_SLOT = IW'(NSYM - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEL  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      state;
  logic [NSYM-1:0] active;
  logic [NW-1:0]   cnt [NSYM];
  logic [NSYM-1:0] msk [NSYM];
  logic [IW-1:0]   load_ptr;
  logic [IW-1:0]   idx_a;
  logic [IW-1:0]   idx_b;

  logic [IW-1:0]   sel_a;
  logic [IW-1:0]   sel_b;
  logic            have_a;
  logic            have_b;
  logic [KW-1:0]   key_a;
  logic [KW-1:0]   key_b;
  logic [KW-1:0]   key_i;
  logic [IW-1:0]   merge_lo;
  logic [IW-1:0]   merge_hi;
  logic            leaf_on;

  // Single pass keeps the two smallest {count, mask} keys; masks of active nodes are
  // disjoint and non-zero, so keys never tie.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    have_a = 1'b0;
    have_b = 1'b0;
    key_a  = '1;
    key_b  = '1;
    key_i  = '0;
    for (int unsigned i = 0; i < NSYM; i++) begin
      key_i = {cnt[i], msk[i]};
      if (active[i]) begin
        if (!have_a || key_i < key_a) begin
          key_b  = key_a;
          sel_b  = sel_a;
          have_b = have_a;
          key_a  = key_i;
          sel_a  = IW'(i);
          have_a = 1'b1;
        end else if (!have_b || key_i < key_b) begin
          key_b  = key_i;
          sel_b  = IW'(i);
          have_b = 1'b1;
        end
      end
    end
  end

  always_comb begin
    merge_lo = (idx_a < idx_b) ? idx_a : idx_b;
    merge_hi = (idx_a < idx_b) ? idx_b : idx_a;
  end

`ifdef HME_ZERO_SKIP_EN
  assign leaf_on = |load_data;
`else
  assign leaf_on = 1'b1;
`endif

  assign load_ready = (state == S_LOAD);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      active       <= '0;
      load_ptr     <= '0;
      idx_a        <= '0;
      idx_b        <= '0;
      merge_valid  <= 1'b0;
      merge_sum    <= '0;
      merge_mask_a <= '0;
      merge_mask_b <= '0;
      for (int unsigned i = 0; i < NSYM; i++) begin
        cnt[i] <= '0;
        msk[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            load_ptr <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            cnt[load_ptr]    <= NW'(load_data);
            msk[load_ptr]    <= NSYM'(1) << load_ptr;
            active[load_ptr] <= leaf_on;
            if (load_ptr == LAST_SLOT) begin
              state <= S_SEL;
            end else begin
              load_ptr <= load_ptr + 1'b1;
            end
          end
        end
        S_SEL: begin
          if (!have_b) begin
            state <= S_DONE;
          end else begin
            merge_sum    <= cnt[sel_a] + cnt[sel_b];
            merge_mask_a <= msk[sel_a];
            merge_mask_b <= msk[sel_b];
            idx_a        <= sel_a;
            idx_b        <= sel_b;
            merge_valid  <= 1'b1;
            state        <= S_OUT;
          end
        end
        S_OUT: begin
          // Merged node lands in the lower slot so surviving indices stay stable.
          if (merge_ready) begin
            cnt[merge_lo]    <= merge_sum;
            msk[merge_lo]    <= merge_mask_a | merge_mask_b;
            active[merge_hi] <= 1'b0;
            merge_valid      <= 1'b0;
            state            <= S_SEL;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_merge_engine.sv
// Scoreboard bench for huffman_merge_engine: NSYM=6 and NSYM=4 instances, directed
// vectors with hand-computed merge records; expectations follow HME_ZERO_SKIP_EN.
module tb_huffman_merge_engine;

  typedef struct packed {
    logic [11:0] sum;
    logic [5:0]  ma;
    logic [5:0]  mb;
  } rec6_t;

  typedef struct packed {
    logic [11:0] sum;
    logic [3:0]  ma;
    logic [3:0]  mb;
  } rec4_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start6, load_valid6, load_ready6, mv6, mr6, busy6, done6_o;
  logic [7:0]  load_data6;
  logic [11:0] sum6;
  logic [5:0]  ma6, mb6;

  logic        start4, load_valid4, load_ready4, mv4, mr4, busy4, done4_o;
  logic [7:0]  load_data4;
  logic [11:0] sum4;
  logic [3:0]  ma4, mb4;

  rec6_t q6[$];
  rec4_t q4[$];
  int n_assert = 0;
  int n_fail   = 0;
  int pops6 = 0, pops4 = 0, done6 = 0, done4 = 0, stall6 = 0;

  huffman_merge_engine #(.NSYM(6), .CW(8)) u_dut6 (
    .clk(clk), .reset(reset), .start(start6),
    .load_valid(load_valid6), .load_data(load_data6), .load_ready(load_ready6),
    .merge_valid(mv6), .merge_ready(mr6), .merge_sum(sum6),
    .merge_mask_a(ma6), .merge_mask_b(mb6), .busy(busy6), .done(done6_o)
  );

  huffman_merge_engine #(.NSYM(4), .CW(8)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .load_valid(load_valid4), .load_data(load_data4), .load_ready(load_ready4),
    .merge_valid(mv4), .merge_ready(mr4), .merge_sum(sum4),
    .merge_mask_a(ma4), .merge_mask_b(mb4), .busy(busy4), .done(done4_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push6(input int s, input logic [5:0] a, input logic [5:0] b);
    q6.push_back({12'(s), a, b});
  endtask

  task automatic push4(input int s, input logic [3:0] a, input logic [3:0] b);
    q4.push_back({12'(s), a, b});
  endtask

  task automatic push_ref6();
    push6(14,  6'b000001, 6'b000010);
    push6(25,  6'b000100, 6'b001000);
    push6(30,  6'b000011, 6'b010000);
    push6(55,  6'b001100, 6'b010011);
    push6(100, 6'b100000, 6'b011111);
  endtask

  task automatic build6(input logic [7:0] c [6], input bit hold_start);
    start6 = 1'b1;
    tick();
    if (!hold_start) start6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid6 = 1'b1;
      load_data6  = c[i];
      if (i == 0) check("load_ready6_in_load", load_ready6, 1);
      tick();
    end
    load_valid6 = 1'b0;
    load_data6  = '0;
    start6      = 1'b0;
  endtask

  task automatic build4(input logic [7:0] c [4]);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid4 = 1'b1;
      load_data4  = c[i];
      tick();
    end
    load_valid4 = 1'b0;
    load_data4  = '0;
  endtask

  task automatic wait_done6(input int base);
    int k = 0;
    while (done6 == base && k < 300) begin
      tick();
      k++;
    end
    check("done6_seen", (done6 > base), 1);
    tick(3);
    check("done6_once", done6, base + 1);
    check("q6_drained", q6.size(), 0);
  endtask

  task automatic wait_pops6(input int target);
    int k = 0;
    while (pops6 < target && k < 300) begin
      tick();
      k++;
    end
    check("pops6_reached", pops6, target);
  endtask

  task automatic wait_valid6();
    int k = 0;
    while (!mv6 && k < 50) begin
      tick();
      k++;
    end
    check("valid6_seen", mv6, 1);
  endtask

  logic [7:0] v6 [6];
  logic [7:0] v4 [4];
  int base, sbase;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (done6_o) done6++;
        if (done4_o) done4++;
        if (mv6) begin
          if (q6.size() == 0) begin
            check("rec6_unexpected", {sum6, ma6, mb6}, 0);
          end else begin
            check("rec6", {sum6, ma6, mb6}, q6[0]);
            if (mr6) begin
              void'(q6.pop_front());
              pops6++;
            end else begin
              stall6++;
            end
          end
        end
        if (mv4) begin
          if (q4.size() == 0) begin
            check("rec4_unexpected", {sum4, ma4, mb4}, 0);
          end else begin
            check("rec4", {sum4, ma4, mb4}, q4[0]);
            if (mr4) begin
              void'(q4.pop_front());
              pops4++;
            end
          end
        end
      end
    join_none

    reset = 1'b1;
    start6 = 0; load_valid6 = 0; load_data6 = '0; mr6 = 1'b1;
    start4 = 0; load_valid4 = 0; load_data4 = '0; mr4 = 1'b1;
    tick(2);
    check("reset6_outputs", {busy6, mv6, done6_o, load_ready6, sum6, ma6, mb6}, 0);
    check("reset4_outputs", {busy4, mv4, done4_o, load_ready4, sum4, ma4, mb4}, 0);
    reset = 1'b0;
    tick();

    // load_valid in IDLE must not write anything
    load_valid6 = 1'b1;
    load_data6  = 8'hFF;
    tick(2);
    check("load_ready6_idle", load_ready6, 0);
    check("busy6_idle", busy6, 0);
    load_valid6 = 1'b0;

    // Reference vector, consumer always ready
    push_ref6();
    v6 = '{8'd5, 8'd9, 8'd12, 8'd13, 8'd16, 8'd45};
    base = done6;
    build6(v6, 1'b0);
    wait_done6(base);

    // Four equal leaves on the NSYM=4 instance
    push4(2, 4'b0001, 4'b0010);
    push4(2, 4'b0100, 4'b1000);
    push4(4, 4'b0011, 4'b1100);
    v4 = '{8'd1, 8'd1, 8'd1, 8'd1};
    base = done4;
    build4(v4);
    for (int k = 0; k < 100 && done4 == base; k++) tick();
    tick(3);
    check("done4_once", done4, base + 1);
    check("q4_drained", q4.size(), 0);

    // Sparse counts with zero leaves
`ifdef HME_ZERO_SKIP_EN
    push6(10, 6'b100000, 6'b000100);
`else
    push6(0,  6'b000001, 6'b000010);
    push6(0,  6'b000011, 6'b001000);
    push6(0,  6'b001011, 6'b010000);
    push6(3,  6'b011011, 6'b100000);
    push6(10, 6'b111011, 6'b000100);
`endif
    v6 = '{8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd3};
    base = done6;
    build6(v6, 1'b0);
    wait_done6(base);

    // Single non-zero leaf
`ifndef HME_ZERO_SKIP_EN
    push6(0, 6'b000001, 6'b000010);
    push6(0, 6'b000011, 6'b000100);
    push6(0, 6'b000111, 6'b001000);
    push6(0, 6'b001111, 6'b010000);
    push6(9, 6'b011111, 6'b100000);
`endif
    v6 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9};
    base = done6;
    build6(v6, 1'b0);
    wait_done6(base);

    // Back-pressure: consumer stalls step 2 for three cycles
    push_ref6();
    v6 = '{8'd5, 8'd9, 8'd12, 8'd13, 8'd16, 8'd45};
    base  = done6;
    sbase = stall6;
    build6(v6, 1'b0);
    wait_pops6(pops6 + 1);
    mr6 = 1'b0;
    wait_valid6();
    tick(3);
    mr6 = 1'b1;
    wait_done6(base);
    check("stall6_cycles", stall6 - sbase, 3);

    // Reset while step 3 is held in OUT aborts the build
    push_ref6();
    base = done6;
    build6(v6, 1'b0);
    wait_pops6(pops6 + 2);
    mr6 = 1'b0;
    wait_valid6();
    reset = 1'b1;
    #1;
    check("abort6_outputs", {busy6, mv6, done6_o, load_ready6, sum6, ma6, mb6}, 0);
    q6.delete();
    tick();
    reset = 1'b0;
    mr6 = 1'b1;
    tick(10);
    check("abort6_no_done", done6, base);
    check("abort6_idle", busy6, 0);

    // Fresh build after abort, start held high through LOAD
`ifdef HME_ZERO_SKIP_EN
    push6(10, 6'b100000, 6'b000100);
`else
    push6(0,  6'b000001, 6'b000010);
    push6(0,  6'b000011, 6'b001000);
    push6(0,  6'b001011, 6'b010000);
    push6(3,  6'b011011, 6'b100000);
    push6(10, 6'b111011, 6'b000100);
`endif
    v6 = '{8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd3};
    base = done6;
    build6(v6, 1'b1);
    wait_done6(base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 2000000");
    $fatal(1);
  end

endmodule
